// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Raster timing generator: signed xpos/ypos counters with registered sync,
// data-enable, vertical-blank pulse, frame counter and sticky vblank IRQ.
module vga_timing_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int HSYNC_ACTIVE = 0,
    parameter int VSYNC_ACTIVE = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               irq_ack,
    output logic               hsync,
    output logic               vsync,
    output logic               data_en,
    output logic signed [15:0] xpos,
    output logic signed [15:0] ypos,
    output logic               vblank,
    output logic               vblank_start,
    output logic [8:0]         frame,
    output logic               irq
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;

    localparam logic signed [15:0] X_FIRST  = 16'(-H_BLANK);
    localparam logic signed [15:0] X_LAST   = 16'(H_ACTIVE - 1);
    localparam logic signed [15:0] HS_FIRST = 16'(-H_BLANK + H_FP);
    localparam logic signed [15:0] HS_LAST  = 16'(-H_BP - 1);
    localparam logic signed [15:0] Y_FIRST  = 16'(-V_BLANK);
    localparam logic signed [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
    localparam logic signed [15:0] VS_FIRST = 16'(-V_BLANK + V_FP);
    localparam logic signed [15:0] VS_LAST  = 16'(-V_BP - 1);

    localparam logic HS_ON = (HSYNC_ACTIVE != 0);
    localparam logic VS_ON = (VSYNC_ACTIVE != 0);

    logic signed [15:0] x_q, x_d;
    logic signed [15:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               data_en_q, data_en_d;
    logic               vblank_q, vblank_d;
    logic               vblank_start_q, vblank_start_d;
    logic [8:0]         frame_q, frame_d;
    logic               irq_q, irq_d;
    logic               frame_end;

    // Outputs are decoded from the next-state position so every registered
    // output lines up with the xpos/ypos presented in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        x_d       = x_q + 16'sd1;
        y_d       = y_q;
        frame_end = 1'b0;
        if (x_q == X_LAST) begin
            x_d = X_FIRST;
            if (y_q == Y_LAST) begin
                y_d       = Y_FIRST;
                frame_end = 1'b1;
            end else begin
                y_d = y_q + 16'sd1;
            end
        end

        hsync_d        = (x_d >= HS_FIRST && x_d <= HS_LAST) ? HS_ON : ~HS_ON;
        vsync_d        = (y_d >= VS_FIRST && y_d <= VS_LAST) ? VS_ON : ~VS_ON;
        data_en_d      = (x_d >= 16'sd0) && (y_d >= 16'sd0);
        vblank_d       = (y_d < 16'sd0);
        vblank_start_d = frame_end;
        frame_d        = frame_q + 9'(frame_end);
        // A new vblank wins over a simultaneous acknowledge.
        irq_d          = frame_end | (irq_q & ~irq_ack);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q            <= X_FIRST;
            y_q            <= Y_FIRST;
            hsync_q        <= ~HS_ON;
            vsync_q        <= ~VS_ON;
            data_en_q      <= 1'b0;
            vblank_q       <= 1'b1;
            vblank_start_q <= 1'b0;
            frame_q        <= 9'd0;
            irq_q          <= 1'b0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            data_en_q      <= data_en_d;
            vblank_q       <= vblank_d;
            vblank_start_q <= vblank_start_d;
            frame_q        <= frame_d;
            irq_q          <= irq_d;
        end
    end

    assign xpos         = x_q;
    assign ypos         = y_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign data_en      = data_en_q;
    assign vblank       = vblank_q;
    assign vblank_start = vblank_start_q;
    assign frame        = frame_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_timing_gen on a shrunken raster: a time-based
// reference model queues expected outputs, a monitor pops and compares.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int HSYNC_ACTIVE = 0, VSYNC_ACTIVE = 1;
    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int HT = H_ACTIVE + H_BLANK;
    localparam int VT = V_ACTIVE + V_BLANK;
    localparam int FT = HT * VT;
    localparam logic HS_ON = (HSYNC_ACTIVE != 0);
    localparam logic VS_ON = (VSYNC_ACTIVE != 0);

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [8:0]         frame;
        logic               hs, vs, de, vb, vbs, irq;
    } obs_t;

    logic clk, resetn, irq_ack;
    logic hsync, vsync, data_en, vblank, vblank_start, irq;
    logic signed [15:0] xpos, ypos;
    logic [8:0] frame;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_ACTIVE(HSYNC_ACTIVE), .VSYNC_ACTIVE(VSYNC_ACTIVE)
    ) dut (
        .clk(clk), .resetn(resetn), .irq_ack(irq_ack),
        .hsync(hsync), .vsync(vsync), .data_en(data_en),
        .xpos(xpos), .ypos(ypos), .vblank(vblank),
        .vblank_start(vblank_start), .frame(frame), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Reference: everything follows from cycles elapsed since reset release.
    function automatic obs_t model(input longint t, input logic irq_v);
        int pix, line, xi, yi;
        obs_t o;
        pix     = int'(t % HT);
        line    = int'((t / HT) % VT);
        xi      = pix - H_BLANK;
        yi      = line - V_BLANK;
        o.x     = 16'(xi);
        o.y     = 16'(yi);
        o.frame = 9'((t / FT) % 512);
        o.hs    = (xi >= -H_BLANK + H_FP && xi < -H_BLANK + H_FP + H_SYNC) ? HS_ON : ~HS_ON;
        o.vs    = (yi >= -V_BLANK + V_FP && yi < -V_BLANK + V_FP + V_SYNC) ? VS_ON : ~VS_ON;
        o.de    = (xi >= 0) && (yi >= 0);
        o.vb    = (yi < 0);
        o.vbs   = (t != 0) && (t % FT == 0);
        o.irq   = irq_v;
        return o;
    endfunction

    function automatic obs_t dut_now();
        obs_t o;
        o.x = xpos; o.y = ypos; o.frame = frame;
        o.hs = hsync; o.vs = vsync; o.de = data_en;
        o.vb = vblank; o.vbs = vblank_start; o.irq = irq;
        return o;
    endfunction

    obs_t   exp_q[$];
    longint t_m;
    logic   irq_m;

    task automatic step(input logic ack);
        irq_ack = ack;
        t_m++;
        if (t_m % FT == 0) irq_m = 1'b1;
        else if (ack)      irq_m = 1'b0;
        exp_q.push_back(model(t_m, irq_m));
        @(posedge clk);
        #2;
    endtask

    // Monitor: statistics are taken from DUT outputs, independent of the model.
    obs_t mon_got, mon_exp;
    logic count_en = 1'b0;
    int   hs_cnt = 0, vs_cnt = 0, de_cnt = 0, vbs_cnt = 0;
    logic signed [15:0] first_hs_x, first_vs_x, first_vs_y;
    logic [8:0] prev_frame = 9'd0;
    logic wrap_seen = 1'b0;

    always @(posedge clk) begin
        #1;
        if (resetn) begin
            mon_got = dut_now();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: DUT output with no queued expectation");
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard", mon_got, mon_exp);
            end
            if (count_en) begin
                if (mon_got.hs == HS_ON) begin
                    if (hs_cnt == 0) first_hs_x = mon_got.x;
                    hs_cnt++;
                end
                if (mon_got.vs == VS_ON) begin
                    if (vs_cnt == 0) begin
                        first_vs_x = mon_got.x;
                        first_vs_y = mon_got.y;
                    end
                    vs_cnt++;
                end
                if (mon_got.de)  de_cnt++;
                if (mon_got.vbs) vbs_cnt++;
            end
            if (prev_frame == 9'd511 && mon_got.frame == 9'd0) wrap_seen = 1'b1;
            prev_frame = mon_got.frame;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b1; irq_ack = 1'b0; t_m = 0; irq_m = 1'b0;
        #3 resetn = 1'b0;
        #20;
        check("reset_state", dut_now(), model(0, 1'b0));
        check("reset_xpos", xpos, -H_BLANK);
        check("reset_ypos", ypos, -V_BLANK);

        // One full frame from reset.
        @(negedge clk);
        resetn = 1'b1;
        count_en = 1'b1;
        repeat (FT) step(1'b0);
        count_en = 1'b0;
        check("hsync_cycles", hs_cnt, H_SYNC * VT);
        check("vsync_cycles", vs_cnt, V_SYNC * HT);
        check("data_en_cycles", de_cnt, H_ACTIVE * V_ACTIVE);
        check("vblank_start_pulses", vbs_cnt, 1);
        check("first_hsync_x", first_hs_x, -H_BLANK + H_FP);
        check("first_vsync_x", first_vs_x, -H_BLANK);
        check("first_vsync_y", first_vs_y, -V_BLANK + V_FP);
        check("frame_after_one", frame, 1);
        check("vbs_at_frame_end", vblank_start, 1);
        check("irq_set", irq, 1);

        // IRQ acknowledge, then ack held across the next vblank_start.
        repeat (10) step(1'b0);
        step(1'b1);
        check("irq_ack_clears", irq, 0);
        while ((t_m + 1) % FT != 0) step(1'b0);
        step(1'b1);
        check("set_beats_ack_vbs", vblank_start, 1);
        check("set_beats_ack_irq", irq, 1);
        step(1'b1);
        check("held_ack_clears", irq, 0);

        // Random acknowledges across enough frames to wrap the frame counter.
        repeat (512 * FT) step(1'(($urandom_range(0, 7) == 0)));
        check("frame_wrap_seen", wrap_seen, 1);

        // Park mid-frame with irq set, then pulse reset between clock edges.
        while (t_m % FT != 0) step(1'b0);
        while (t_m % FT != (2 + V_BLANK) * HT + (5 + H_BLANK)) step(1'b0);
        check("pre_reset_x", xpos, 5);
        check("pre_reset_y", ypos, 2);
        check("pre_reset_irq", irq, 1);
        check("pre_reset_frame_nonzero", frame != 9'd0, 1);
        #2 resetn = 1'b0;
        #1;
        check("async_reset", dut_now(), model(0, 1'b0));
        check("async_reset_queue", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        t_m = 0;
        irq_m = 1'b0;
        repeat (2 * FT) step(1'(($urandom_range(0, 3) == 0)));
        check("final_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
